sram_arb: RTL and testbench
===========================

Name: sram_arb

Overview:
- Arbitrates `NREQ` requesters onto one single-port, byte-masked SRAM macro.
- The SRAM has one-cycle registered read latency and returns read-before-write data.
- Provides round-robin arbitration, optional grant locking for multi-cycle read-modify-write sequences, and response routing.
- Optionally clears the whole array after reset. Sits between the cache controllers and the tag/data SRAM instance.

Parameters:
- WIDTH, 32, SRAM word width in bits.
- LG_DEPTH, 10, log2 of the number of SRAM words.
- BYTESIZE, 8, bits per byte-mask lane; NB = WIDTH/BYTESIZE.
- NREQ, 2, number of requesters (at least 1).

Ports:
- clk  in  1  clock; also drives the SRAM CE pin externally.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  grant; a handshake occurs when valid and ready are both high.
- req_write  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  hold the grant after this handshake.
- req_addr  in  NREQ*LG_DEPTH  packed word addresses.
- req_bm  in  NREQ*NB  packed byte masks (writes only).
- req_wdata  in  NREQ*WIDTH  packed write data.
- rsp_valid  out  NREQ  one-hot response strobe.
- rsp_data  out  WIDTH  SRAM output; qualified by rsp_valid.
- init_done  out  1  high once the array is usable.
- sram_a  out  LG_DEPTH  SRAM address.
- sram_bm  out  NB  SRAM byte mask.
- sram_web  out  1  SRAM write enable, active-low.
- sram_csb  out  1  SRAM chip select, active-low.
- sram_oeb  out  1  SRAM output enable, tied 0.
- sram_i  out  WIDTH  SRAM write data.
- sram_o  in  WIDTH  SRAM read data.

Behaviour:
- Reset values:
  - state = ST_INIT, init counter = 0, rr pointer = 0, lock = none.
  - rsp_valid = 0, init_done = 0, req_ready = 0.
  - sram_csb = 1, sram_web = 1.
- Reset asserted mid-operation:
  - Aborts everything; any pending response is dropped.
  - The clear sequence restarts from address 0.
- ST_INIT (clear sequence):
  - Each cycle drives sram_csb=0, sram_web=0, sram_bm all ones, sram_i=0, sram_a=counter.
  - The counter increments each cycle. After address 2**LG_DEPTH-1 is written, state moves to ST_RUN.
  - init_done rises on the first ST_RUN cycle; total clear time is 2**LG_DEPTH cycles.
  - req_ready stays 0 throughout; no responses are generated.
- ST_RUN grant selection (combinational):
  - Eligible set: all requesters, or only the lock owner while a lock is held.
  - The grant goes to the first eligible valid requester, searching from the rr pointer upward with wrap-around.
  - Only the granted requester's req_ready is high; at most one handshake per cycle.
  - The granted request drives the SRAM pins directly: a=addr, bm=bm, web=~write, i=wdata, csb=0.
  - With no grant: csb=1, web=1, and the other SRAM pins are don't-care.
- Pointer and lock updates on a handshake from requester g:
  - Pointer becomes (g+1) mod NREQ; it holds on cycles with no handshake.
  - If req_lock[g] is 1, owner becomes g and the lock is held.
  - A handshake by the owner with req_lock=0 releases the lock.
  - While locked and the owner is idle, there is no grant and the SRAM is idle; other requesters wait.
- Response path:
  - rsp_valid[g] is registered high exactly one cycle after the handshake, for both reads and writes.
  - rsp_data = sram_o combinationally during that cycle.
  - A write response returns the word's pre-write contents, enabling atomic swap.
  - There is no response backpressure; requesters must accept their responses.
- Throughput:
  - Back-to-back handshakes every cycle, with overlapping responses.
  - A read issued the cycle after a write to the same address returns the new data.

Optional Feature:
- Macro: SRAM_ARB_INIT_EN.
- Defined: the ST_INIT clear sequence runs as described above.
- Undefined:
  - Reset enters ST_RUN directly and the counter logic is omitted.
  - init_done resets to 0 and becomes 1 on the first clock edge after reset deasserts.
  - Array contents are undefined.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef enum logic {ST_INIT, ST_RUN} sram_arb_state_t.
  - Function rr_pick(valid, ptr, NREQ) returning a one-hot grant.
- One sub-module, sram_arb_rr, holds the rr pointer and lock-owner registers and produces the one-hot grant.
- sram_arb does the SRAM muxing, the init FSM and the response register.

Test Plan:
- Clear sequence (INIT_EN, LG_DEPTH=4): release reset → exactly 16 writes at addresses 0..15 with data 0; init_done high on cycle 17; a read of address 5 returns 0.
- Round-robin fairness: both requesters hold valid reads for 6 cycles → grants alternate 0,1,0,1,0,1; each rsp_valid is one cycle after its grant.
- Swap with byte mask (WIDTH=32, BYTESIZE=8): write 0xAABBCCDD to address 3, then write 0x11223344 with bm=4'b0011 → second response returns 0xAABBCCDD; a following read returns 0xAABB3344.
- Lock: requester 1 reads address 7 with lock=1, idles 2 cycles, then writes with lock=0 while requester 0 is continuously valid → requester 0 is not granted until the cycle after requester 1's unlocked write.
- Reset mid-run: assert reset in the cycle after a read handshake → no rsp_valid; init restarts at address 0; init_done is 0.
- Read-after-write: write 0x5 to address 9, then read address 9 in the next cycle → read response 0x5.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin pick function for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {ST_INIT, ST_RUN} sram_arb_state_t;

  localparam int unsigned MAX_NREQ = 32;

  // One-hot grant to the first set bit of valid at or above ptr, wrapping at nreq.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input int unsigned         ptr,
    input int unsigned         nreq
  );
    logic [MAX_NREQ-1:0] gnt;
    logic [5:0]          idx;
    logic                found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      if (k < nreq) begin
        idx = 6'(ptr) + 6'(k);
        if (idx >= 6'(nreq)) idx = idx - 6'(nreq);
        if (!found && valid[idx[4:0]]) begin
          gnt[idx[4:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sram_arb_if.sv
// Requester handshake, response and SRAM macro pins of the arbiter.
interface sram_arb_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LG_DEPTH = 10,
  parameter int unsigned BYTESIZE = 8,
  parameter int unsigned NREQ     = 2
);
  localparam int unsigned NB = WIDTH / BYTESIZE;

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          req_write;
  logic [NREQ-1:0]          req_lock;
  logic [NREQ*LG_DEPTH-1:0] req_addr;
  logic [NREQ*NB-1:0]       req_bm;
  logic [NREQ*WIDTH-1:0]    req_wdata;
  logic [NREQ-1:0]          rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     init_done;
  logic [LG_DEPTH-1:0]      sram_a;
  logic [NB-1:0]            sram_bm;
  logic                     sram_web;
  logic                     sram_csb;
  logic                     sram_oeb;
  logic [WIDTH-1:0]         sram_i;
  logic [WIDTH-1:0]         sram_o;

  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_bm, req_wdata, sram_o,
    output req_ready, rsp_valid, rsp_data, init_done,
           sram_a, sram_bm, sram_web, sram_csb, sram_oeb, sram_i
  );

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_bm, req_wdata, sram_o,
    input  req_ready, rsp_valid, rsp_data, init_done,
           sram_a, sram_bm, sram_web, sram_csb, sram_oeb, sram_i
  );

endinterface

// File: rtl/sram_arb_rr.sv
// Round-robin pointer and grant-lock owner; produces the one-hot grant.
module sram_arb_rr
  import sram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_i,
  input  logic [NREQ-1:0] valid_i,
  input  logic [NREQ-1:0] lock_i,
  output logic [NREQ-1:0] gnt_c_o
);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic             locked_q, locked_d;
  logic [PTR_W-1:0] gidx_c;
  logic [NREQ-1:0]  elig_c;
  logic [NREQ-1:0]  gnt_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

  // While locked only the owner is eligible, so an idle owner stalls everyone.
  always_comb begin
    elig_c   = locked_q ? (NREQ'(1) << owner_q) : '1;
    gnt_c    = run_i ? NREQ'(rr_pick(MAX_NREQ'(valid_i & elig_c), 32'(ptr_q), NREQ)) : '0;
    gidx_c   = '0;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (gnt_c[r]) gidx_c = PTR_W'(r);
    end
    if (gnt_c != '0) begin
      ptr_d = (32'(gidx_c) == NREQ - 1) ? '0 : gidx_c + PTR_W'(1);
      if (lock_i[gidx_c]) begin
        locked_d = 1'b1;
        owner_d  = gidx_c;
      end else begin
        locked_d = 1'b0;
      end
    end
  end

  assign gnt_c_o = gnt_c;

endmodule

// File: rtl/sram_arb.sv
// Arbitrates NREQ requesters onto one single-port byte-masked SRAM.
// Define SRAM_ARB_INIT_EN to clear the whole array after reset.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LG_DEPTH = 10,
  parameter int unsigned BYTESIZE = 8,
  parameter int unsigned NREQ     = 2
) (
  input  logic      clk,
  input  logic      reset,
  sram_arb_if.slave bus
);
  localparam int unsigned NB = WIDTH / BYTESIZE;

  sram_arb_state_t     state_q, state_d;
  logic                init_done_q, init_done_d;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [NREQ-1:0]     gnt_c;
  logic                init_c, run_c;
  logic [LG_DEPTH-1:0] init_addr_c;
  logic [LG_DEPTH-1:0] sram_a_c;
  logic [NB-1:0]       sram_bm_c;
  logic [WIDTH-1:0]    sram_i_c;
  logic                sram_web_c, sram_csb_c;

`ifdef SRAM_ARB_INIT_EN
  logic [LG_DEPTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + LG_DEPTH'(1);
      if (cnt_q == '1) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  // Held off while reset is asserted so the macro stays deselected.
  assign init_c      = (state_q == ST_INIT) && !reset;
  assign init_addr_c = cnt_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = ST_RUN;
    init_done_d = 1'b1;
  end

  assign init_c      = 1'b0;
  assign init_addr_c = '0;
`endif

  assign run_c = init_done_q && (state_q == ST_RUN);

  sram_arb_rr #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .run_i   (run_c),
    .valid_i (bus.req_valid),
    .lock_i  (bus.req_lock),
    .gnt_c_o (gnt_c)
  );

  // Clear writes or the granted request drive the macro pins directly.
  always_comb begin
    sram_csb_c = 1'b1;
    sram_web_c = 1'b1;
    sram_a_c   = '0;
    sram_bm_c  = '0;
    sram_i_c   = '0;
    if (init_c) begin
      sram_csb_c = 1'b0;
      sram_web_c = 1'b0;
      sram_a_c   = init_addr_c;
      sram_bm_c  = '1;
    end else begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (gnt_c[r]) begin
          sram_csb_c = 1'b0;
          sram_web_c = ~bus.req_write[r];
          sram_a_c   = bus.req_addr[r*LG_DEPTH +: LG_DEPTH];
          sram_bm_c  = bus.req_bm[r*NB +: NB];
          sram_i_c   = bus.req_wdata[r*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_valid_q <= '0;
    else       rsp_valid_q <= gnt_c;
  end

  assign bus.req_ready = gnt_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = bus.sram_o;
  assign bus.init_done = init_done_q;
  assign bus.sram_a    = sram_a_c;
  assign bus.sram_bm   = sram_bm_c;
  assign bus.sram_web  = sram_web_c;
  assign bus.sram_csb  = sram_csb_c;
  assign bus.sram_oeb  = 1'b0;
  assign bus.sram_i    = sram_i_c;

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: SRAM macro model, reference memory and response scoreboard.
module tb_sram_arb;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned LG_DEPTH = 4;
  localparam int unsigned BYTESIZE = 8;
  localparam int unsigned NREQ     = 2;
  localparam int unsigned NB       = 4;
  localparam int unsigned DEPTH    = 16;

  typedef struct {
    int          who;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arb_if #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH), .BYTESIZE(BYTESIZE), .NREQ(NREQ)) bus ();

  sram_arb #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH), .BYTESIZE(BYTESIZE), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Macro model: registered read, read-before-write, byte-masked write.
  logic [31:0] mem [DEPTH];
  logic [31:0] sram_q;
  logic [31:0] sram_w;
  always @(posedge clk) begin
    if (bus.sram_csb === 1'b0) begin
      sram_q <= mem[bus.sram_a];
      if (bus.sram_web === 1'b0) begin
        sram_w = mem[bus.sram_a];
        for (int b = 0; b < NB; b++)
          if (bus.sram_bm[b]) sram_w[8*b +: 8] = bus.sram_i[8*b +: 8];
        mem[bus.sram_a] = sram_w;
      end
    end
  end
  assign bus.sram_o = sram_q;

  logic [31:0] ref_mem [DEPTH];
  sb_t         sbq [$];
  int          tb_ptr, tb_owner;
  logic        tb_locked, tb_run;

  // Response monitor: pops the entry due this cycle, else no strobe may appear.
  sb_t        mon_e;
  logic [1:0] mon_exp;
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      mon_e   = sbq.pop_front();
      mon_exp = (mon_e.who == 1) ? 2'b10 : 2'b01;
      checks++;
      if (bus.rsp_valid !== mon_exp || bus.rsp_data !== mon_e.data) begin
        errors++;
        $display("FAIL rsp cyc=%0d: got valid=%b data=%h, expected valid=%b data=%h",
                 cyc, bus.rsp_valid, bus.rsp_data, mon_exp, mon_e.data);
      end
    end else begin
      checks++;
      if (bus.rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL rsp_spurious cyc=%0d: got valid=%b, expected 00", cyc, bus.rsp_valid);
      end
    end
  end

  task automatic set_req(input int r, input logic v, input logic w, input logic lk,
                         input logic [3:0] a, input logic [3:0] bm, input logic [31:0] d);
    bus.req_valid[r]          = v;
    bus.req_write[r]          = w;
    bus.req_lock[r]           = lk;
    bus.req_addr[r*4 +: 4]    = a;
    bus.req_bm[r*4 +: 4]      = bm;
    bus.req_wdata[r*32 +: 32] = d;
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic model_reset();
    tb_ptr    = 0;
    tb_owner  = 0;
    tb_locked = 1'b0;
    tb_run    = 1'b0;
    sbq.delete();
  endtask

  // Predicts this cycle's grant and, on a handshake, queues the response and updates memory.
  task automatic model_issue(output logic [1:0] g);
    logic [1:0]  m;
    logic [3:0]  a;
    logic [3:0]  bm;
    logic [31:0] w;
    int          idx;
    sb_t         e;
    m = bus.req_valid & (tb_locked ? ((tb_owner == 0) ? 2'b01 : 2'b10) : 2'b11);
    if (!tb_run)         g = 2'b00;
    else if (m == 2'b11) g = (tb_ptr == 0) ? 2'b01 : 2'b10;
    else                 g = m;
    if (g != 2'b00) begin
      idx    = g[1] ? 1 : 0;
      a      = bus.req_addr[idx*4 +: 4];
      bm     = bus.req_bm[idx*4 +: 4];
      e.who  = idx;
      e.data = ref_mem[a];
      e.cyc  = cyc + 1;
      sbq.push_back(e);
      if (bus.req_write[idx]) begin
        w = ref_mem[a];
        for (int b = 0; b < 4; b++)
          if (bm[b]) w[8*b +: 8] = bus.req_wdata[idx*32 + 8*b +: 8];
        ref_mem[a] = w;
      end
      tb_ptr    = 1 - idx;
      tb_locked = bus.req_lock[idx];
      tb_owner  = idx;
    end
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'h1, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b1, 1'b0, 4'h2, 4'hF, 32'h1234);
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b, expected 00", bus.req_ready); end
    checks++;
    if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b, expected 0", bus.init_done); end
    checks++;
    if ({bus.sram_csb, bus.sram_web} !== 2'b11) begin
      errors++; $display("FAIL reset_sram: got csb/web=%b%b, expected 11", bus.sram_csb, bus.sram_web);
    end
  endtask

  task automatic test_init();
    logic [1:0] g;
    idle_all();
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd5, 4'hF, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef SRAM_ARB_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      #3;
      checks++;
      if (bus.sram_csb !== 1'b0 || bus.sram_web !== 1'b0 || bus.sram_a !== 4'(i) ||
          bus.sram_bm !== 4'hF || bus.sram_i !== 32'h0) begin
        errors++;
        $display("FAIL init_write %0d: got csb=%b web=%b a=%0d bm=%h i=%h, expected 0 0 %0d f 0",
                 i, bus.sram_csb, bus.sram_web, bus.sram_a, bus.sram_bm, bus.sram_i, i);
      end
      checks++;
      if (bus.req_ready !== 2'b00 || bus.init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_idle %0d: got ready=%b init_done=%b, expected 00 0", i, bus.req_ready, bus.init_done);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
`else
    #3;
    checks++;
    if (bus.init_done !== 1'b0 || bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL init_first: got init_done=%b ready=%b, expected 0 00", bus.init_done, bus.req_ready);
    end
    @(posedge clk); #1;
`endif
    tb_run = 1'b1;
    #3;
    checks++;
    if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b, expected 1", bus.init_done); end
    model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL init_grant: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    idle_all();
`ifdef SRAM_ARB_INIT_EN
    #3;
    checks++;
    if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL init_read5: got %h, expected 0", bus.rsp_data); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #3;
      model_issue(g);
      checks++;
      if (bus.req_ready !== g) begin errors++; $display("FAIL rr_grant %0d: got %b, expected %b", k, bus.req_ready, g); end
      checks++;
      if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_order %0d: got %b, expected alternating from 01", k, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    idle_all();
    @(posedge clk); #1;
  endtask

  task automatic test_swap();
    logic [1:0] g;
    set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 32'hAABBCCDD);
    #3; model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL swap_w1: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 4'b0011, 32'h11223344);
    #3; model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL swap_w2: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'hF, 32'h0);
    #3;
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'hAABBCCDD) begin
      errors++; $display("FAIL swap_old: got valid=%b data=%h, expected 01 aabbccdd", bus.rsp_valid, bus.rsp_data);
    end
    model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL swap_rd: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    idle_all();
    #3;
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'hAABB3344) begin
      errors++; $display("FAIL swap_merge: got valid=%b data=%h, expected 01 aabb3344", bus.rsp_valid, bus.rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    logic [1:0] g;
    logic [1:0] lock_exp [5] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      set_req(1, 1'b1, 1'b0, 1'b1, 4'd7, 4'hF, 32'h0);
      else if (k == 3) set_req(1, 1'b1, 1'b1, 1'b0, 4'd7, 4'hF, 32'h77770007);
      else             set_req(1, 1'b0, 1'b0, 1'b0, 4'd7, 4'hF, 32'h0);
      #3;
      model_issue(g);
      checks++;
      if (bus.req_ready !== g) begin errors++; $display("FAIL lock_grant %0d: got %b, expected %b", k, bus.req_ready, g); end
      checks++;
      if (bus.req_ready !== lock_exp[k]) begin
        errors++; $display("FAIL lock_seq %0d: got %b, expected %b", k, bus.req_ready, lock_exp[k]);
      end
      @(posedge clk); #1;
    end
    idle_all();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    set_req(1, 1'b1, 1'b1, 1'b0, 4'd9, 4'hF, 32'h5);
    #3; model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL raw_w: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd9, 4'hF, 32'h0);
    #3; model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL raw_r: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    idle_all();
    #3;
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'h5) begin
      errors++; $display("FAIL raw_data: got valid=%b data=%h, expected 10 00000005", bus.rsp_valid, bus.rsp_data);
    end
    @(posedge clk); #1;
    for (int n = 0; n < 24; n++) begin
      for (int r = 0; r < 2; r++)
        set_req(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                4'($urandom_range(0, 15)), 4'($urandom), 32'($urandom));
      #3; model_issue(g);
      checks++;
      if (bus.req_ready !== g) begin errors++; $display("FAIL b2b_grant %0d: got %b, expected %b", n, bus.req_ready, g); end
      @(posedge clk); #1;
    end
    idle_all();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] g;
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd2, 4'hF, 32'h0);
    #3; model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL mid_grant: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    idle_all();
    #3;
    checks++;
    if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_rsp_drop: got %b, expected 00", bus.rsp_valid); end
    checks++;
    if (bus.init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %b, expected 0", bus.init_done); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #3;
    checks++;
    if (bus.init_done !== 1'b0) begin errors++; $display("FAIL mid_release: got init_done=%b, expected 0", bus.init_done); end
`ifdef SRAM_ARB_INIT_EN
    checks++;
    if (bus.sram_csb !== 1'b0 || bus.sram_web !== 1'b0 || bus.sram_a !== 4'd0) begin
      errors++; $display("FAIL mid_restart: got csb=%b web=%b a=%0d, expected 0 0 0", bus.sram_csb, bus.sram_web, bus.sram_a);
    end
    repeat (DEPTH) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
`else
    @(posedge clk); #1;
`endif
    tb_run = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd2, 4'hF, 32'h0);
    #3;
    checks++;
    if (bus.init_done !== 1'b1) begin errors++; $display("FAIL mid_done: got %b, expected 1", bus.init_done); end
    model_issue(g);
    checks++;
    if (bus.req_ready !== g) begin errors++; $display("FAIL mid_read: got %b, expected %b", bus.req_ready, g); end
    @(posedge clk); #1;
    idle_all();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hC0DE0000 | 32'(i);
      ref_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    sram_q = 32'h0;
    idle_all();
    model_reset();
    test_reset();
    test_init();
    test_round_robin();
    test_swap();
    test_lock();
    test_back_to_back();
    test_reset_mid_run();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL rsp_missing: got %0d pending, expected 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
